// File: rtl/sim_ctrl.sv
// sim_ctrl: OCP slave giving software an ID register, a 64-bit cycle counter,
// a scratch register, a buffered console byte stream and a sticky exit request.
module sim_ctrl #(
    parameter logic [31:0] ID_VALUE   = 32'h53494D43,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] i_MAddr,
    input  logic [2:0]  i_MCmd,
    input  logic [31:0] i_MData,
    input  logic [3:0]  i_MByteEn,
    output logic        o_SCmdAccept,
    output logic [31:0] o_SData,
    output logic [1:0]  o_SResp,
    output logic        o_halt,
    output logic [7:0]  o_exit_code,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    localparam logic [2:0] IDX_ID      = 3'd0;
    localparam logic [2:0] IDX_CYC_LO  = 3'd1;
    localparam logic [2:0] IDX_CYC_HI  = 3'd2;
    localparam logic [2:0] IDX_EXIT    = 3'd3;
    localparam logic [2:0] IDX_SCRATCH = 3'd4;
    localparam logic [2:0] IDX_CONSOLE = 3'd5;

    logic [63:0]                 cyc_q, cyc_d;
    logic [31:0]                 hi_q, hi_d;
    logic [31:0]                 scratch_q, scratch_d;
    logic                        halt_q, halt_d;
    logic [7:0]                  code_q, code_d;
    logic [1:0]                  resp_q, resp_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [AW:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW:0]                 rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH-1:0][7:0]  mem_q, mem_d;

    logic [2:0] idx;
    logic       is_wr, is_rd, acc, full, empty, push, pop;

    // Address bits outside [4:2] carry no meaning for this device.
    logic unused_addr;
    assign unused_addr = ^{i_MAddr[31:5], i_MAddr[1:0]};

    assign idx   = i_MAddr[4:2];
    assign is_wr = (i_MCmd == CMD_WR);
    assign is_rd = (i_MCmd == CMD_RD);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Only a console push into a full FIFO stalls; uses pre-pop full flag.
    assign o_SCmdAccept = !(is_wr && (idx == IDX_CONSOLE) && full);
    assign acc  = (i_MCmd != CMD_IDLE) && o_SCmdAccept;
    assign push = acc && is_wr && (idx == IDX_CONSOLE);
    assign pop  = !empty && i_tx_ready;

    assign o_SResp     = resp_q;
    assign o_SData     = rdata_q;
    assign o_halt      = halt_q;
    assign o_exit_code = code_q;
    assign o_tx_valid  = !empty;
    assign o_tx_data   = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state: register decode, response generation, FIFO pointers, counter.
    always_comb begin
        cyc_d     = cyc_q + 64'd1;
        hi_d      = hi_q;
        scratch_d = scratch_q;
        halt_d    = halt_q;
        code_d    = code_q;
        resp_d    = RESP_NULL;
        rdata_d   = 32'd0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_d     = mem_q;

        if (acc) begin
            if (!(is_wr || is_rd) || (idx > IDX_CONSOLE)) begin
                resp_d = RESP_ERR;
            end else begin
                resp_d = RESP_DVA;
                if (is_rd) begin
                    case (idx)
                        IDX_ID:      rdata_d = ID_VALUE;
                        IDX_CYC_LO: begin
                            rdata_d = cyc_q[31:0];
                            hi_d    = cyc_q[63:32];
                        end
                        IDX_CYC_HI:  rdata_d = hi_q;
                        IDX_SCRATCH: rdata_d = scratch_q;
                        default:     rdata_d = 32'd0;
                    endcase
                end else begin
                    case (idx)
                        IDX_EXIT: begin
                            // First exit request wins; the code is frozen afterwards.
                            if (!halt_q) begin
                                halt_d = 1'b1;
                                code_d = i_MData[7:0];
                            end
                        end
                        IDX_SCRATCH: begin
                            for (int b = 0; b < 4; b++)
                                if (i_MByteEn[b]) scratch_d[b*8 +: 8] = i_MData[b*8 +: 8];
                        end
                        default: ;
                    endcase
                end
            end
        end

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = i_MData[7:0];
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // State registers, all cleared asynchronously (drops any pending response).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cyc_q     <= '0;
            hi_q      <= '0;
            scratch_q <= '0;
            halt_q    <= 1'b0;
            code_q    <= '0;
            resp_q    <= RESP_NULL;
            rdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_q     <= '0;
        end else begin
            cyc_q     <= cyc_d;
            hi_q      <= hi_d;
            scratch_q <= scratch_d;
            halt_q    <= halt_d;
            code_q    <= code_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
        end
    end
endmodule

// File: tb/tb_sim_ctrl.sv
// Directed testbench for sim_ctrl: register map, console FIFO, exit, counter, errors.
module tb_sim_ctrl;
    localparam logic [2:0] WR = 3'b001, RD = 3'b010;
    localparam logic [1:0] NUL = 2'b00, DVA = 2'b01, ERR = 2'b11;
    localparam logic [31:0] ID = 32'h53494D43;

    logic        clk, nrst;
    logic [31:0] i_MAddr, i_MData;
    logic [2:0]  i_MCmd;
    logic [3:0]  i_MByteEn;
    logic        o_SCmdAccept, o_halt, o_tx_valid, i_tx_ready;
    logic [31:0] o_SData;
    logic [1:0]  o_SResp;
    logic [7:0]  o_exit_code, o_tx_data;

    int checks = 0;
    int errors = 0;

    sim_ctrl dut (
        .clk(clk), .nrst(nrst), .i_MAddr(i_MAddr), .i_MCmd(i_MCmd),
        .i_MData(i_MData), .i_MByteEn(i_MByteEn), .o_SCmdAccept(o_SCmdAccept),
        .o_SData(o_SData), .o_SResp(o_SResp), .o_halt(o_halt),
        .o_exit_code(o_exit_code), .o_tx_valid(o_tx_valid),
        .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One accepted transfer: drive at negedge, return the response seen after the edge.
    task automatic bus(input logic [2:0] cmd, input logic [2:0] idx, input logic [31:0] data,
                       input logic [3:0] be, output logic [1:0] resp, output logic [31:0] rdata);
        @(negedge clk);
        i_MCmd    = cmd;
        i_MAddr   = {27'h1234567, idx, 2'b01};
        i_MData   = data;
        i_MByteEn = be;
        @(posedge clk);
        #1;
        resp   = o_SResp;
        rdata  = o_SData;
        i_MCmd = 3'b000;
    endtask

    task automatic test_reset();
        logic [1:0] r; logic [31:0] d;
        nrst = 1'b0; i_MCmd = 3'b000; i_MAddr = '0; i_MData = '0; i_MByteEn = '0; i_tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_SResp, o_SData, o_halt, o_exit_code, o_tx_valid} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs got resp=%h data=%h halt=%b code=%h txv=%b expected all zero",
                     o_SResp, o_SData, o_halt, o_exit_code, o_tx_valid);
        end
        @(negedge clk); nrst = 1'b1;
        bus(RD, 3'd0, 32'd0, 4'hF, r, d);
        checks++;
        if (r !== DVA || d !== ID) begin
            errors++; $display("FAIL read_id got %h/%h expected %h/%h", r, d, DVA, ID);
        end
        @(posedge clk); #1;
        checks++;
        if (o_SResp !== NUL || o_SData !== 32'd0) begin
            errors++; $display("FAIL resp_one_cycle got %h/%h expected 0/0", o_SResp, o_SData);
        end
    endtask

    task automatic test_scratch();
        logic [1:0] r; logic [31:0] d;
        bus(WR, 3'd4, 32'hAABBCCDD, 4'b1111, r, d);
        bus(WR, 3'd4, 32'h11223344, 4'b0101, r, d);
        checks++;
        if (r !== DVA) begin errors++; $display("FAIL scratch_wr_resp got %h expected %h", r, DVA); end
        bus(RD, 3'd4, 32'd0, 4'h0, r, d);
        checks++;
        if (r !== DVA || d !== 32'hAA22CC44) begin
            errors++; $display("FAIL scratch_bytes got %h/%h expected 1/aa22cc44", r, d);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        i_MCmd = RD; i_MAddr = {27'd0, 3'd0, 2'b00};
        @(posedge clk); #1;
        checks++;
        if (o_SResp !== DVA || o_SData !== ID) begin
            errors++; $display("FAIL b2b_first got %h/%h expected 1/%h", o_SResp, o_SData, ID);
        end
        i_MAddr = {27'd0, 3'd4, 2'b00};
        @(posedge clk); #1;
        checks++;
        if (o_SResp !== DVA || o_SData !== 32'hAA22CC44) begin
            errors++; $display("FAIL b2b_second got %h/%h expected 1/aa22cc44", o_SResp, o_SData);
        end
        i_MCmd = 3'b000;
        @(posedge clk); #1;
        checks++;
        if (o_SResp !== NUL) begin errors++; $display("FAIL b2b_idle got %h expected 0", o_SResp); end
    endtask

    task automatic test_ro_wo();
        logic [1:0] r; logic [31:0] d;
        bus(WR, 3'd0, 32'hDEADBEEF, 4'hF, r, d);
        checks++;
        if (r !== DVA) begin errors++; $display("FAIL wr_ro_resp got %h expected 1", r); end
        bus(RD, 3'd0, 32'd0, 4'hF, r, d);
        checks++;
        if (d !== ID) begin errors++; $display("FAIL id_unchanged got %h expected %h", d, ID); end
        bus(RD, 3'd3, 32'd0, 4'hF, r, d);
        checks++;
        if (r !== DVA || d !== 32'd0) begin errors++; $display("FAIL rd_exit got %h/%h expected 1/0", r, d); end
        bus(RD, 3'd5, 32'd0, 4'hF, r, d);
        checks++;
        if (r !== DVA || d !== 32'd0) begin errors++; $display("FAIL rd_console got %h/%h expected 1/0", r, d); end
    endtask

    task automatic test_console();
        logic [1:0] r; logic [31:0] d;
        i_tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus(WR, 3'd5, 32'(i), 4'hF, r, d);
            checks++;
            if (r !== DVA) begin errors++; $display("FAIL push%0d_resp got %h expected 1", i, r); end
        end
        checks++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'd1) begin
            errors++; $display("FAIL tx_head got %b/%h expected 1/01", o_tx_valid, o_tx_data);
        end
        @(negedge clk);
        i_MCmd = WR; i_MAddr = {27'd0, 3'd5, 2'b00}; i_MData = 32'd5;
        #1;
        checks++;
        if (o_SCmdAccept !== 1'b0) begin errors++; $display("FAIL full_stall got %b expected 0", o_SCmdAccept); end
        @(negedge clk); i_tx_ready = 1'b1;
        #1;
        checks++;
        if (o_SCmdAccept !== 1'b0) begin errors++; $display("FAIL full_pop_stall got %b expected 0", o_SCmdAccept); end
        @(posedge clk); #1;
        checks++;
        if (o_SCmdAccept !== 1'b1 || o_tx_data !== 8'd2) begin
            errors++; $display("FAIL after_pop got acc=%b data=%h expected 1/02", o_SCmdAccept, o_tx_data);
        end
        @(posedge clk); #1;
        i_MCmd = 3'b000;
        checks++;
        if (o_SResp !== DVA || o_tx_data !== 8'd3) begin
            errors++; $display("FAIL push5 got resp=%h data=%h expected 1/03", o_SResp, o_tx_data);
        end
        for (int b = 4; b <= 5; b++) begin
            @(posedge clk); #1;
            checks++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== 8'(b)) begin
                errors++; $display("FAIL tx_byte%0d got %b/%h expected 1/%h", b, o_tx_valid, o_tx_data, b);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got %b expected 0", o_tx_valid); end
        i_tx_ready = 1'b0;
    endtask

    task automatic test_exit();
        logic [1:0] r; logic [31:0] d;
        checks++;
        if (o_halt !== 1'b0) begin errors++; $display("FAIL halt_pre got %b expected 0", o_halt); end
        bus(WR, 3'd3, 32'h0000012A, 4'hF, r, d);
        checks++;
        if (r !== DVA || o_halt !== 1'b1 || o_exit_code !== 8'h2A) begin
            errors++; $display("FAIL exit_first got resp=%h halt=%b code=%h expected 1/1/2a", r, o_halt, o_exit_code);
        end
        bus(WR, 3'd3, 32'h00000007, 4'hF, r, d);
        checks++;
        if (r !== DVA || o_halt !== 1'b1 || o_exit_code !== 8'h2A) begin
            errors++; $display("FAIL exit_second got resp=%h halt=%b code=%h expected 1/1/2a", r, o_halt, o_exit_code);
        end
    endtask

    task automatic test_counter();
        logic [1:0] r; logic [31:0] d;
        @(negedge clk);
        force dut.cyc_q = 64'h00000000_FFFFFFFE;
        @(negedge clk);
        release dut.cyc_q;
        repeat (3) @(posedge clk);
        bus(RD, 3'd1, 32'd0, 4'hF, r, d);
        checks++;
        if (r !== DVA || d !== 32'd1) begin errors++; $display("FAIL cyc_lo got %h/%h expected 1/00000001", r, d); end
        bus(RD, 3'd2, 32'd0, 4'hF, r, d);
        checks++;
        if (r !== DVA || d !== 32'd1) begin errors++; $display("FAIL cyc_hi got %h/%h expected 1/00000001", r, d); end
    endtask

    task automatic test_err();
        logic [1:0] r; logic [31:0] d;
        bus(RD, 3'd6, 32'd0, 4'hF, r, d);
        checks++;
        if (r !== ERR || d !== 32'd0) begin errors++; $display("FAIL rd_idx6 got %h/%h expected 3/0", r, d); end
        bus(WR, 3'd7, 32'h12345678, 4'hF, r, d);
        checks++;
        if (r !== ERR) begin errors++; $display("FAIL wr_idx7 got %h expected 3", r); end
        bus(3'b100, 3'd4, 32'd0, 4'hF, r, d);
        checks++;
        if (r !== ERR || d !== 32'd0) begin errors++; $display("FAIL bad_cmd got %h/%h expected 3/0", r, d); end
        bus(RD, 3'd0, 32'd0, 4'hF, r, d);
        #1 nrst = 1'b0;
        #1;
        checks++;
        if ({o_SResp, o_SData, o_halt, o_exit_code, o_tx_valid} !== 44'd0) begin
            errors++;
            $display("FAIL reset_in_resp got resp=%h data=%h halt=%b code=%h txv=%b expected all zero",
                     o_SResp, o_SData, o_halt, o_exit_code, o_tx_valid);
        end
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_SResp !== NUL) begin errors++; $display("FAIL no_resp_after_reset got %h expected 0", o_SResp); end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_back_to_back();
        test_ro_wo();
        test_console();
        test_exit();
        test_counter();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sim_ctrl.md
Name: sim_ctrl

Overview:
- OCP slave device on the system interconnect through which software running on the core signals the simulation environment.
- Gives software:
  - a fixed ID register
  - a 64-bit free-running cycle counter
  - a scratch register
  - a buffered console byte channel
  - an exit/halt request carrying an exit code
- The top-level environment watches o_halt/o_exit_code and drains the console stream. This is the device-to-environment direction, complementing the environment driving clock and reset into the system.

Parameters:
- ID_VALUE, 32'h53494D43, value returned by the ID register.
- FIFO_DEPTH, 4, console FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- i_MAddr  in  32  OCP address; only bits [4:2] are decoded, all other bits are ignored.
- i_MCmd  in  3  OCP command: IDLE=000, WR=001, RD=010; any other encoding is treated as an error command.
- i_MData  in  32  OCP write data.
- i_MByteEn  in  4  OCP byte enables.
- o_SCmdAccept  out  1  command accepted this cycle.
- o_SData  out  32  read data.
- o_SResp  out  2  response: NULL=00, DVA=01, ERR=11.
- o_halt  out  1  sticky exit request.
- o_exit_code  out  8  exit code latched with o_halt.
- o_tx_valid  out  1  console byte available.
- o_tx_data  out  8  console byte.
- i_tx_ready  in  1  consumer takes byte when o_tx_valid & i_tx_ready.

Behaviour:
- Reset: all registers and outputs clear asynchronously on nrst=0:
  - o_SResp=NULL, o_SData=0, o_halt=0, o_exit_code=0, o_tx_valid=0
  - FIFO empty, cycle counter=0, scratch=0, HI snapshot=0
  - Reset mid-transaction drops any pending response; no response is issued after reset release.
- Handshake:
  - Command accepted in cycle N when i_MCmd!=IDLE and o_SCmdAccept=1.
  - Response appears in cycle N+1 for exactly one cycle. o_SResp=NULL and o_SData=0 in every other cycle.
  - Back-to-back accepts are allowed; one response per accepted command, in order.
- o_SCmdAccept (combinational): 0 only when i_MCmd=WR, word index=5 and FIFO is full; 1 otherwise.
- Register map (word index = i_MAddr[4:2]):
  - 0 ID: RO, returns ID_VALUE.
  - 1 CYC_LO: RO, returns counter[31:0]; same edge latches counter[63:32] into HI snapshot.
  - 2 CYC_HI: RO, returns HI snapshot.
  - 3 EXIT: WO. Write sets o_halt=1 and o_exit_code=i_MData[7:0] on the accepting edge. Only the first EXIT write is honoured; later EXIT writes get DVA but leave o_exit_code unchanged. Cleared only by reset.
  - 4 SCRATCH: RW; writes honour i_MByteEn per byte.
  - 5 CONSOLE: WO, pushes i_MData[7:0] into FIFO; reads return 0 with DVA.
  - 6, 7: any access -> ERR, o_SData=0, no state change.
- Read/write rules:
  - Writes to RO registers -> DVA, ignored.
  - Reads of WO registers -> DVA with data 0.
  - Non-RD/WR command -> ERR.
  - Byte enables are ignored except for SCRATCH.
- Cycle counter: 64-bit, increments every cycle after reset release, wraps to 0 from all-ones.
- Console FIFO:
  - Pointers carry an extra wrap bit for full/empty.
  - o_tx_valid = !empty; o_tx_data = head entry.
  - Simultaneous push and pop when full: the push is still stalled (accept depends on the full flag before the pop). The pop completes this cycle, so the push is accepted the next cycle.
  - Simultaneous push and pop when non-full, non-empty: count unchanged, both succeed.
  - Push into empty FIFO: o_tx_valid rises the next cycle.
- o_halt does not block further bus traffic.

Test Plan:
- Reset then RD idx0 -> o_SResp=DVA, o_SData=32'h53494D43 one cycle after accept; NULL the following cycle.
- Write SCRATCH 32'hAABBCCDD with ByteEn=1111, then write 32'h11223344 with ByteEn=0101, then read -> 32'hAA22CC44.
- Hold i_tx_ready=0 and issue 5 CONSOLE writes (bytes 1..5) -> first 4 accepted, 5th sees o_SCmdAccept=0. Raise i_tx_ready -> bytes 1,2,3,4,5 emerge in order; 5th write accepted the cycle after the first pop.
- Write EXIT 32'h0000012A -> o_halt=1, o_exit_code=8'h2A next cycle. Second EXIT write of 8'h07 -> DVA, code stays 8'h2A.
- Force counter to 64'h00000000_FFFFFFFE via backdoor, wait 3 cycles, read CYC_LO then CYC_HI -> HI snapshot=1; CYC_LO reflects the wrapped low word.
- RD idx6, WR idx7, MCmd=3'b100 -> ERR each. Assert nrst=0 in the response cycle -> o_SResp=NULL immediately, all outputs at reset values.
